// File: rtl/extension_cero_pkg.sv
// Shared constants for the immediate-extension unit: mode encodings and default widths.
package ext_pkg;
  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;

  localparam int IMM_W_DEF = 16;
  localparam int OUT_W_DEF = 32;
endpackage

// File: rtl/extension_cero_if.sv
// Decode-side bus for the extension unit: raw immediate and mode in, extended operands out.
interface extension_cero_if
  import ext_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) ();
  logic [IMM_W-1:0] immediate;
  logic [1:0]       mode;
  logic             load;
  logic [OUT_W-1:0] output_imm;
  logic [OUT_W-1:0] ext_out;
  logic             ext_valid;

  modport master (
    output immediate, mode, load,
    input  output_imm, ext_out, ext_valid
  );

  modport slave (
    input  immediate, mode, load,
    output output_imm, ext_out, ext_valid
  );
endinterface

// File: rtl/extension_cero_ext_mux.sv
// Combinational extension legs (zero/sign/upper/branch) with mode select.
module ext_mux
  import ext_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] zero_ext,
  output logic [OUT_W-1:0] sel_ext
);
  localparam int PAD_W = OUT_W - IMM_W;

  logic [OUT_W-1:0] sign_ext, upper_ext, branch_ext;

  assign zero_ext   = {{PAD_W{1'b0}}, imm};
  assign sign_ext   = {{PAD_W{imm[IMM_W-1]}}, imm};
  assign upper_ext  = {imm, {PAD_W{1'b0}}};
  // word-aligned branch offset; top two sign bits fall off the end
  assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};

  always_comb begin
    sel_ext = zero_ext;
    unique case (mode)
      EXT_ZERO:   sel_ext = zero_ext;
      EXT_SIGN:   sel_ext = sign_ext;
      EXT_UPPER:  sel_ext = upper_ext;
      EXT_BRANCH: sel_ext = branch_ext;
      default:    sel_ext = zero_ext;
    endcase
  end
endmodule

// File: rtl/extension_cero.sv
// Decode-stage immediate extender: combinational zero-extend plus a registered mode-selected result.
module extension_cero
  import ext_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  extension_cero_if.slave  bus
);
  logic [OUT_W-1:0] zero_ext, sel_ext, ext_q;
  logic             vld_q;

  ext_mux #(.IMM_W(IMM_W), .OUT_W(OUT_W)) u_mux (
    .imm      (bus.immediate),
    .mode     (bus.mode),
    .zero_ext (zero_ext),
    .sel_ext  (sel_ext)
  );

  // reset clears asynchronously and masks load for as long as it is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= '0;
      vld_q <= 1'b0;
    end else if (bus.load) begin
      ext_q <= sel_ext;
      vld_q <= 1'b1;
    end
  end

  assign bus.output_imm = zero_ext;
  assign bus.ext_out    = ext_q;
  assign bus.ext_valid  = vld_q;
endmodule

// File: tb/tb_extension_cero.sv
// Self-checking bench for extension_cero: directed cases then randomized traffic against an arithmetic model.
module tb_extension_cero;
  logic clk = 1'b0;
  logic rst;
  logic clk_run = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_out;
  logic        exp_vld;

  extension_cero_if #(.IMM_W(16), .OUT_W(32)) bus ();

  extension_cero #(.IMM_W(16), .OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference: extension rules as plain integer arithmetic on a 16-bit value.
  function automatic logic [31:0] ref_ext(input int unsigned imm, input int unsigned md);
    longint s;
    s = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
    case (md)
      0: return 32'(imm);
      1: return 32'(s & 64'hFFFF_FFFF);
      2: return 32'((longint'(imm) * 65536) & 64'hFFFF_FFFF);
      default: return 32'((s * 4) & 64'hFFFF_FFFF);
    endcase
  endfunction

  // One clock: drive at negedge, check combinational path, step model at posedge, check registers.
  task automatic cyc(input logic [15:0] imm, input logic [1:0] md, input logic ld, input logic r);
    bus.immediate = imm;
    bus.mode      = md;
    bus.load      = ld;
    rst           = r;
    if (r) begin exp_out = '0; exp_vld = 1'b0; end
    #1;
    chk("output_imm", bus.output_imm, {16'h0, imm});
    @(posedge clk);
    if (!r && ld) begin
      exp_out = ref_ext(imm, md);
      exp_vld = 1'b1;
    end
    #1;
    chk("ext_out", bus.ext_out, exp_out);
    chk("ext_valid", {31'h0, bus.ext_valid}, {31'h0, exp_vld});
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] comb_vals [4];
    logic [15:0] r_imm;
    logic [1:0]  r_md;
    logic        r_ld, r_rst;

    comb_vals = '{16'd0, 16'd7, 16'd3840, 16'hAAAA};
    rst = 1'b1;
    bus.immediate = '0;
    bus.mode = 2'b00;
    bus.load = 1'b0;
    exp_out = '0;
    exp_vld = 1'b0;
    #1;
    chk("reset ext_out", bus.ext_out, 32'h0);
    chk("reset ext_valid", {31'h0, bus.ext_valid}, 32'h0);

    // clock idle: zero path must settle combinationally
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.immediate = comb_vals[i];
      #0;
      chk("comb zero", bus.output_imm, {16'h0, comb_vals[i]});
      #10;
    end
    chk("idle ext_valid", {31'h0, bus.ext_valid}, 32'h0);

    clk_run = 1'b1;
    @(negedge clk);

    // directed sign/zero/upper/branch
    cyc(16'hAAAA, 2'b00, 1'b1, 1'b0);
    cyc(16'hAAAA, 2'b01, 1'b1, 1'b0);
    chk("sign AAAA", bus.ext_out, 32'hFFFF_AAAA);
    cyc(16'h7FFF, 2'b01, 1'b1, 1'b0);
    chk("sign 7FFF", bus.ext_out, 32'h0000_7FFF);
    cyc(16'h1234, 2'b10, 1'b1, 1'b0);
    chk("upper 1234", bus.ext_out, 32'h1234_0000);
    cyc(16'hFFFF, 2'b11, 1'b1, 1'b0);
    chk("branch FFFF", bus.ext_out, 32'hFFFF_FFFC);
    cyc(16'h0004, 2'b11, 1'b1, 1'b0);
    chk("branch 0004", bus.ext_out, 32'h0000_0010);

    // hold
    cyc(16'h0007, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(16'hBEEF, 2'b01, 1'b0, 1'b0);
    chk("hold ext_out", bus.ext_out, 32'h0000_0007);
    chk("hold output_imm", bus.output_imm, 32'h0000_BEEF);

    // async reset pulse between edges
    cyc(16'h5555, 2'b01, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst ext_out", bus.ext_out, 32'h0);
    chk("async rst ext_valid", {31'h0, bus.ext_valid}, 32'h0);
    exp_out = '0;
    exp_vld = 1'b0;
    @(negedge clk);
    // reset held with load: no capture
    cyc(16'h1234, 2'b10, 1'b1, 1'b1);
    cyc(16'h1234, 2'b10, 1'b0, 1'b0);
    chk("rst+load no capture", bus.ext_out, 32'h0);

    // back-to-back
    for (int i = 1; i <= 4; i++) begin
      cyc(16'(i), 2'b00, 1'b1, 1'b0);
      chk("b2b seq", bus.ext_out, 32'(i));
    end

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r_imm = 16'($urandom);
      r_md  = 2'($urandom_range(0, 3));
      r_ld  = ($urandom_range(0, 3) != 0);
      r_rst = ($urandom_range(0, 19) == 0);
      cyc(r_imm, r_md, r_ld, r_rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
